// File: rtl/axi_iw_slot_allocator.sv
// axi_iw_slot_allocator
// Maps wide upstream AXI IDs onto a small set of downstream ID slots for one
// direction (AW/B or AR/R). Each slot remembers the upstream ID that owns it
// and how many transactions are outstanding on it. A slot is free when its
// count is zero.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    request beat offered
//   req_id_i       upstream ID of the offered beat
//   req_ready_o    request may be forwarded (push on valid & ready)
//   req_oup_id_o   slot assigned to req_id_i (meaningful when req_ready_o=1)
//   rsp_valid_i    one transaction completed
//   rsp_oup_id_i   slot of the completing transaction
//   rsp_inp_id_o   upstream ID stored in slot rsp_oup_id_i (combinational)
//   full_o         every slot holds at least one transaction
//   busy_o         at least one transaction outstanding
//   outstanding_o  total outstanding transactions
module axi_iw_slot_allocator #(
  parameter int InpIdWidth   = 8,
  parameter int MaxUniqIds   = 4,
  parameter int MaxTxnsPerId = 4,
  parameter int OupIdWidth   = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1,
  parameter int CntWidth     = $clog2(MaxTxnsPerId + 1),
  parameter int TotWidth     = $clog2(MaxUniqIds * MaxTxnsPerId + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [InpIdWidth-1:0] req_id_i,
  output logic                  req_ready_o,
  output logic [OupIdWidth-1:0] req_oup_id_o,
  input  logic                  rsp_valid_i,
  input  logic [OupIdWidth-1:0] rsp_oup_id_i,
  output logic [InpIdWidth-1:0] rsp_inp_id_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic [TotWidth-1:0]   outstanding_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

  logic [InpIdWidth-1:0] id_reg   [MaxUniqIds];
  logic [CntWidth-1:0]   cnt_reg  [MaxUniqIds];
  logic [InpIdWidth-1:0] id_next  [MaxUniqIds];
  logic [CntWidth-1:0]   cnt_next [MaxUniqIds];

  logic [MaxUniqIds-1:0] hit_vec;
  logic [MaxUniqIds-1:0] free_vec;
  logic [MaxUniqIds-1:0] push_vec;
  logic [MaxUniqIds-1:0] pop_vec;

  logic                  hit;
  logic                  any_free;
  logic [OupIdWidth-1:0] hit_idx;
  logic [OupIdWidth-1:0] free_idx;
  logic [OupIdWidth-1:0] sel_idx;
  logic [CntWidth-1:0]   sel_cnt;
  logic [CntWidth-1:0]   rsp_cnt;
  logic                  ready_raw;
  logic                  push;
  logic [TotWidth-1:0]   total;

  // Per-slot match / free flags and next-state.
  genvar gi;
  generate
    for (gi = 0; gi < MaxUniqIds; gi++) begin : g_slot
      assign free_vec[gi] = (cnt_reg[gi] == '0);
      assign hit_vec[gi]  = !free_vec[gi] && (id_reg[gi] == req_id_i);
      assign push_vec[gi] = push && (sel_idx == OupIdWidth'(gi));
      // A pop on an empty slot is illegal and deliberately ignored.
      assign pop_vec[gi]  = rsp_valid_i && (rsp_oup_id_i == OupIdWidth'(gi)) &&
                            !free_vec[gi];
      assign cnt_next[gi] = cnt_reg[gi] + CntWidth'(push_vec[gi]) - CntWidth'(pop_vec[gi]);
      // Ownership only changes when a free slot is claimed by a miss.
      assign id_next[gi]  = (push_vec[gi] && !hit) ? req_id_i : id_reg[gi];
    end
  endgenerate

  // Lookup uses registered state only, so a same-cycle pop never affects the grant.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    sel_cnt  = '0;
    rsp_cnt  = '0;
    rsp_inp_id_o = '0;
    total    = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (!hit && hit_vec[i]) begin
        hit     = 1'b1;
        hit_idx = OupIdWidth'(i);
      end
      if (!any_free && free_vec[i]) begin
        any_free = 1'b1;
        free_idx = OupIdWidth'(i);
      end
      if (rsp_oup_id_i == OupIdWidth'(i)) begin
        rsp_inp_id_o = id_reg[i];
        rsp_cnt      = cnt_reg[i];
      end
      total = total + TotWidth'(cnt_reg[i]);
    end
    sel_idx = hit ? hit_idx : free_idx;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (sel_idx == OupIdWidth'(i)) begin
        sel_cnt = cnt_reg[i];
      end
    end
  end

  assign ready_raw     = hit ? (sel_cnt != MaxCnt) : any_free;
  // The table clears asynchronously, but ready must also be held low while reset is asserted.
  assign req_ready_o   = ready_raw && !rst_i;
  assign req_oup_id_o  = sel_idx;
  assign push          = req_valid_i && req_ready_o;
  assign outstanding_o = total;
  assign busy_o        = (total != '0);
  assign full_o        = !any_free;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        id_reg[i]  <= '0;
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        id_reg[i]  <= id_next[i];
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

`ifndef SYNTHESIS
  a_req_id_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=> (!req_valid_i || $stable(req_id_i)));
  a_rsp_id_range : assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> (32'(rsp_oup_id_i) < MaxUniqIds));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> (rsp_cnt != '0));
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (sel_cnt != MaxCnt));
`endif

endmodule

// File: doc/axi_iw_slot_allocator.md
Name: axi_iw_slot_allocator

Overview:
- ID-slot scheduler that lets an ID-width converter remap wide upstream AXI IDs onto a small set of downstream IDs ("slots"), for one direction (one instance for AW/B, one for AR/R).
- Tracks which upstream ID owns each slot and how many transactions are outstanding on it.
- Admits a new request only while per-ID ordering and the txn/slot limits hold.
- Sits beside the AW or AR channel mux; the datapath uses its grant, slot index and reverse lookup.

Parameters:
- InpIdWidth, 8: upstream (slave-port) ID width.
- MaxUniqIds, 4: number of downstream slots; must be >= 1 and <= 2**InpIdWidth.
- MaxTxnsPerId, 4: maximum outstanding txns per slot; must be >= 1.
- OupIdWidth, derived = max(1, $clog2(MaxUniqIds)): slot index width.
- CntWidth, derived = $clog2(MaxTxnsPerId+1): per-slot counter width.
- TotWidth, derived = $clog2(MaxUniqIds*MaxTxnsPerId+1): total-outstanding width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset; asynchronous, active-high.
- req_valid_i, in, 1: an AW/AR beat is offered.
- req_id_i, in, InpIdWidth: upstream ID of the offered beat.
- req_ready_o, out, 1: request may be forwarded; push happens on valid&ready.
- req_oup_id_o, out, OupIdWidth: slot assigned to req_id_i; valid only when req_ready_o=1.
- rsp_valid_i, in, 1: one txn completed (B handshake, or R handshake with last).
- rsp_oup_id_i, in, OupIdWidth: slot of the completing txn.
- rsp_inp_id_o, out, InpIdWidth: upstream ID stored in slot rsp_oup_id_i; combinational.
- full_o, out, 1: all slots hold at least one txn.
- busy_o, out, 1: at least one txn outstanding.
- outstanding_o, out, TotWidth: total outstanding txns.

Behaviour:
- State: per slot {id_q[InpIdWidth], cnt_q[CntWidth]}. A slot is free iff cnt_q==0. No other FSM; every output derives from this table.
- Reset while rst_i=1: all cnt_q=0, all id_q=0, req_ready_o=0 (forced), busy_o=0, full_o=0, outstanding_o=0.
- Reset mid-operation discards all bookkeeping immediately. The first cycle after deassertion behaves as a fresh start.
- Lookup is combinational from registered state only. There is no path from rsp_* to req_ready_o or req_oup_id_o.
  - Hit: a used slot has id_q==req_id_i. If cnt_q<MaxTxnsPerId: req_ready_o=1, req_oup_id_o = that slot. Otherwise req_ready_o=0 (stall until a pop registers).
  - Miss with a free slot: req_ready_o=1, req_oup_id_o = lowest-index free slot.
  - Miss with no free slot: req_ready_o=0.
  - req_ready_o does not depend on req_valid_i. It may depend on req_id_i.
- Push (req_valid_i & req_ready_o): cnt_q[slot]+1. On a miss, id_q[slot]<=req_id_i.
- Pop (rsp_valid_i): cnt_q[rsp_oup_id_i]-1. A pop on a slot with cnt_q==0 is illegal: assertion fires and state is unchanged.
- Push and pop in the same cycle:
  - Same slot: cnt unchanged and the slot stays owned.
  - Different slots: each updates independently.
  - A slot freed by a pop is allocatable from the next cycle onward.
- Latency: grant is 0 cycles (combinational). Counter and flag updates are visible 1 cycle after the handshake.
- Ordering guarantee: one upstream ID never occupies two slots at once. This preserves AXI per-ID ordering downstream.
- outstanding_o = sum of cnt_q. busy_o = outstanding_o!=0. full_o = no free slot.
- Assertions: req_id_i stable while req_valid_i & !req_ready_o; rsp_oup_id_i < MaxUniqIds; no counter overflow or underflow.

Test Plan (MaxUniqIds=4, MaxTxnsPerId=4, InpIdWidth=8):
- Reset release, push ID 0x5A -> req_ready_o=1, req_oup_id_o=0; next cycle busy_o=1, outstanding_o=1.
- Push 0x5A x4 -> all on slot 0. 5th offer: req_ready_o=0. Pop slot 0 -> ready=1 in the following cycle, slot 0 again.
- Push 0x01,0x02,0x03,0x04 -> slots 0,1,2,3, full_o=1. Then 0x05 -> ready=0. Then 0x02 -> ready=1 on slot 1, cnt 2.
- Slot 1 at cnt=1, simultaneous push 0x02 and pop slot 1 -> cnt stays 1, id_q[1]=0x02. Pop slot 3's last txn while offering 0x09 with all full -> ready=0 this cycle, next cycle 0x09 gets slot 3.
- Slots 0-2 own 0x10,0x20,0x30; drive rsp_oup_id_i=2 -> rsp_inp_id_o=0x30 in the same cycle.
- With 3 slots busy and outstanding_o=7, pulse rst_i asynchronously between edges -> outstanding_o=0 and req_ready_o=0 immediately. After release, push 0x07 -> slot 0. Pop on an empty slot -> assertion fires, state unchanged.
